// File: rtl/sm83_bcd_serial_alu.sv
// sm83_bcd_serial_alu
//   Multi-byte packed-BCD add/subtract unit. It applies the SM83 binary
//   add/sub followed by DAA one byte per clock, LSB first. The DAA carry or
//   borrow is chained into the next byte. It reports SM83-style Z and C flags
//   for the whole operand.
//
// Ports
//   clk        clock, all state changes on posedge
//   reset_n    synchronous active-low reset, highest priority
//   start      request; accepted when busy=0 (IDLE or DONE cycle)
//   sub        0 = BCD add, 1 = BCD subtract; sampled with start
//   carry_in   carry/borrow into byte 0; sampled with start
//   op_a       augend/minuend, packed BCD; sampled with start
//   op_b       addend/subtrahend, packed BCD; sampled with start
//   busy       high while bytes are being processed
//   done       one-cycle pulse; result/carry_out/zero valid
//   result     adjusted BCD result
//   carry_out  final carry/borrow (C flag)
//   zero       result == 0 (Z flag)
module sm83_bcd_serial_alu #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               sub,
  input  logic               carry_in,
  input  logic [8*BYTES-1:0] op_a,
  input  logic [8*BYTES-1:0] op_b,
  output logic               busy,
  output logic               done,
  output logic [8*BYTES-1:0] result,
  output logic               carry_out,
  output logic               zero
);

  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic          sub_reg;
  logic          chain_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  result_reg;
  logic          carry_reg;
  logic          zero_reg;

  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [8:0]    raw;
  logic [7:0]    corr;
  logic          h_flag;
  logic          c_flag;
  logic [7:0]    byte_out;
  logic [W-1:0]  result_next;

  // Byte-serial binary op followed by DAA on the current byte.
  always_comb begin
    a_byte   = 8'(a_reg >> {idx_reg, 3'b000});
    b_byte   = 8'(b_reg >> {idx_reg, 3'b000});
    raw      = 9'd0;
    corr     = 8'h00;
    h_flag   = 1'b0;
    c_flag   = 1'b0;
    byte_out = 8'h00;
    if (!sub_reg) begin
      raw    = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, chain_reg};
      // Bit-4 sum = a4 ^ b4 ^ carry-into-4, so xor recovers the half carry.
      h_flag = raw[4] ^ a_byte[4] ^ b_byte[4];
      c_flag = raw[8];
      // Both thresholds look at the uncorrected value.
      if (h_flag || (raw[3:0] > 4'd9)) begin
        corr = corr | 8'h06;
      end
      if (c_flag || (raw[7:0] > 8'h99)) begin
        corr   = corr | 8'h60;
        c_flag = 1'b1;
      end
      byte_out = raw[7:0] + corr;
    end else begin
      raw    = {1'b0, a_byte} - {1'b0, b_byte} - {8'd0, chain_reg};
      // Same identity for the difference gives borrow into bit 4.
      h_flag = raw[4] ^ a_byte[4] ^ b_byte[4];
      c_flag = raw[8];
      corr   = (h_flag ? 8'h06 : 8'h00) | (c_flag ? 8'h60 : 8'h00);
      byte_out = raw[7:0] - corr;
    end
  end

  // Result image with the current byte merged in, so the final Z flag can be
  // taken on the same edge that writes the last byte.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_byte
      assign result_next[gi*8 +: 8] = (idx_reg == IW'(gi)) ? byte_out
                                                           : result_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      sub_reg    <= 1'b0;
      chain_reg  <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sub_reg    <= sub;
            chain_reg  <= carry_in;
            a_reg      <= op_a;
            b_reg      <= op_b;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
            idx_reg    <= '0;
            state_reg  <= ST_RUN;
          end else begin
            state_reg  <= ST_IDLE;
          end
        end
        ST_RUN: begin
          result_reg <= result_next;
          chain_reg  <= c_flag;
          if (idx_reg == LAST_IDX) begin
            idx_reg   <= '0;
            carry_reg <= c_flag;
            zero_reg  <= (result_next == '0);
            state_reg <= ST_DONE;
          end else begin
            idx_reg   <= idx_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_reg == ST_RUN);
  assign done      = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign carry_out = carry_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_sm83_bcd_serial_alu.sv
// Testbench for sm83_bcd_serial_alu (BYTES=2): directed cases plus random
// packed-BCD operands checked against a decimal-arithmetic reference.
module tb_sm83_bcd_serial_alu;

  localparam int BYTES = 2;
  localparam int W     = 8 * BYTES;
  localparam int DIG   = 2 * BYTES;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         sub;
  logic         carry_in;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;

  int vec_n  = 0;
  int miss_n = 0;

  sm83_bcd_serial_alu #(.BYTES(BYTES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .sub       (sub),
    .carry_in  (carry_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_n++;
    assert (obs === exp) else begin
      miss_n++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] x);
    longint v = 0;
    for (int i = DIG - 1; i >= 0; i--) v = v * 10 + longint'(x[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    longint t = v;
    for (int i = 0; i < DIG; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Decimal reference: valid-BCD operands behave as plain base-10 arithmetic
  // modulo 10^DIG, with the wrap reported as carry/borrow.
  task automatic model(input logic s, input logic ci, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] r,
                       output logic c);
    longint m = 1;
    longint t;
    for (int i = 0; i < DIG; i++) m = m * 10;
    if (s) begin
      t = bcd2int(a) - bcd2int(b) - longint'(ci);
      c = (t < 0);
      if (t < 0) t = t + m;
    end else begin
      t = bcd2int(a) + bcd2int(b) + longint'(ci);
      c = (t >= m);
      if (t >= m) t = t - m;
    end
    r = int2bcd(t);
  endtask

  task automatic run_op(input string tag, input logic s, input logic ci,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ec, input logic ez);
    int cyc;
    @(negedge clk);
    start = 1'b1; sub = s; carry_in = ci; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, ".busy"}, 64'(busy), 64'(1));
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".lat"}, 64'(cyc), 64'(BYTES + 1));
    check({tag, ".res"}, 64'(result), 64'(er));
    check({tag, ".c"},   64'(carry_out), 64'(ec));
    check({tag, ".z"},   64'(zero), 64'(ez));
    $display("op %s sub=%0d cin=%0d a=%h b=%h -> res=%h c=%0d z=%0d", tag, s, ci, a, b,
             result, carry_out, zero);
    @(negedge clk);
    check({tag, ".done1"}, 64'(done), 64'(0));
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] x = '0;
    for (int i = 0; i < DIG; i++) x[i*4 +: 4] = 4'($urandom_range(9));
    return x;
  endfunction

  initial begin
    logic [W-1:0] ra, rb, rr, rz, exp_r;
    logic rs, rc, exp_c;
    logic [W-1:0] xa, xb, za, zb;
    int cyc;

    reset_n = 1'b0; start = 1'b0; sub = 1'b0; carry_in = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", 64'(busy), 64'(0));
    check("rst.done", 64'(done), 64'(0));
    check("rst.res",  64'(result), 64'(0));
    check("rst.c",    64'(carry_out), 64'(0));
    check("rst.z",    64'(zero), 64'(0));
    reset_n = 1'b1;

    // Directed cases
    run_op("add1999", 1'b0, 1'b0, 16'h1999, 16'h0001, 16'h2000, 1'b0, 1'b0);
    run_op("add9999", 1'b0, 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b1);
    run_op("addcin",  1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0);
    run_op("sub1000", 1'b1, 1'b0, 16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0);
    run_op("sub0000", 1'b1, 1'b0, 16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0);
    run_op("nonbcd",  1'b0, 1'b0, 16'h00AB, 16'h0000, 16'h0111, 1'b0, 1'b0);
    run_op("subzero", 1'b1, 1'b1, 16'h4321, 16'h4320, 16'h0000, 1'b0, 1'b1);

    // Handshake: start held through RUN, operands changed mid-RUN, then a
    // start taken in the DONE cycle.
    xa = 16'h1234; xb = 16'h5678;
    za = 16'h5000; zb = 16'h0001;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; carry_in = 1'b0; op_a = xa; op_b = xb;
    @(negedge clk);
    check("hs.busy", 64'(busy), 64'(1));
    sub = 1'b1; carry_in = 1'b1; op_a = 16'h9999; op_b = 16'h9999;
    @(negedge clk);
    @(negedge clk);
    check("hs.done", 64'(done), 64'(1));
    model(1'b0, 1'b0, xa, xb, exp_r, exp_c);
    check("hs.res", 64'(result), 64'(exp_r));
    check("hs.c",   64'(carry_out), 64'(exp_c));
    $display("op hs1 a=%h b=%h -> res=%h c=%0d", xa, xb, result, carry_out);
    sub = 1'b1; carry_in = 1'b0; op_a = za; op_b = zb;
    @(negedge clk);
    start = 1'b0;
    check("hs2.busy", 64'(busy), 64'(1));
    check("hs2.nodone", 64'(done), 64'(0));
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("hs2.lat", 64'(cyc), 64'(BYTES + 1));
    check("hs2.res", 64'(result), 64'(16'h4999));
    check("hs2.c",   64'(carry_out), 64'(0));
    $display("op hs2 a=%h b=%h -> res=%h c=%0d", za, zb, result, carry_out);
    @(negedge clk);
    check("hs2.done1", 64'(done), 64'(0));

    // Reset during the second byte aborts the operation silently.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; carry_in = 1'b0; op_a = 16'h1111; op_b = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("ab.busy", 64'(busy), 64'(0));
    check("ab.res",  64'(result), 64'(0));
    check("ab.c",    64'(carry_out), 64'(0));
    check("ab.z",    64'(zero), 64'(0));
    for (int i = 0; i < 5; i++) begin
      check("ab.nodone", 64'(done), 64'(0));
      @(negedge clk);
    end
    $display("op abort -> busy=%0d res=%h", busy, result);
    run_op("after", 1'b0, 1'b0, 16'h0450, 16'h0550, 16'h1000, 1'b0, 1'b0);

    // Random valid-BCD operands against the decimal reference.
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rs = 1'($urandom_range(1));
      rc = 1'($urandom_range(1));
      model(rs, rc, ra, rb, rr, exp_c);
      rz = '0;
      run_op("rnd", rs, rc, ra, rb, rr, exp_c, (rr == rz));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
